dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: data word width.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter MAX_BURST, default 8: maximum consecutive locked external grants, range 1..255.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 arst_n  in  1  asynchronous, active-low reset.
REQ-006 core_req / core_wen  in  1 / 1  MEM-stage access request / write qualifier.
REQ-007 core_addr / core_wdata  in  ADDR_W / DATA_W  core address / store data.
REQ-008 core_gnt / core_stall  out  1 / 1  core access accepted this cycle / core_req & ~core_gnt, holds pipeline.
REQ-009 core_rdata / core_rvalid  out  DATA_W / 1  core load data / valid one cycle after granted read.
REQ-010 ext_req / ext_wen / ext_lock  in  1 / 1 / 1  host request / write / burst-lock hold.
REQ-011 ext_addr / ext_wdata  in  ADDR_W / DATA_W  host address / write data.
REQ-012 ext_gnt / ext_rdata / ext_rvalid  out  1 / DATA_W / 1  host grant / read data / read valid.
REQ-013 mem_addr / mem_wdata  out  ADDR_W / DATA_W  to single-port data SRAM.
REQ-014 mem_wen / mem_ren  out  1 / 1  SRAM write / read strobes.
REQ-015 mem_rdata  in  DATA_W  SRAM read data, registered, valid one cycle after mem_ren.

Function
REQ-016 At most one of core_gnt, ext_gnt SHALL be high per cycle; grant is combinational from current requests and registered state.
REQ-017 Single requester SHALL be granted same cycle.
REQ-018 Both requesting, no lock active: winner SHALL be the port not granted most recently (round-robin via last_gnt flop, updated on every grant).
REQ-019 State machine SHALL have states RR, EXT_BURST, YIELD.
REQ-020 RR -> EXT_BURST when ext granted with ext_lock=1; burst counter loads 1.
REQ-021 EXT_BURST: ext SHALL be granted whenever ext_req, regardless of core_req; counter increments per ext grant.
REQ-022 EXT_BURST -> RR when ext_lock=0 or ext_req=0.
REQ-023 EXT_BURST -> YIELD when counter reaches MAX_BURST and core_req=1; if core_req=0 the burst continues and counter saturates at MAX_BURST.
REQ-024 YIELD: core SHALL be granted if core_req, ext denied; always -> RR next cycle.
REQ-025 Granted port drives mem_addr/mem_wdata; mem_wen=req&wen, mem_ren=req&~wen of granted port; no grant: mem_wen=mem_ren=0, addr/wdata=0.
REQ-026 Read owner SHALL be registered with mem_ren; next cycle owner's rvalid=1 and its rdata=mem_rdata; other port rdata=0, rvalid=0.
REQ-027 Write grants SHALL never assert rvalid.
REQ-028 Back-to-back reads SHALL sustain one grant per cycle with rvalid each following cycle.

Reset
REQ-029 arst_n low SHALL force state RR, last_gnt=ext (core wins first conflict), counter=0, read owner cleared.
REQ-030 During reset all grants, strobes, rvalids SHALL be 0, rdata/addr/wdata 0, core_stall=core_req.
REQ-031 Reset asserted mid-read SHALL suppress the pending rvalid.

Configuration
REQ-032 Macro DMEM_ARB_STATS_EN: when defined, add outputs conflict_cnt (32b, increments on cycles with both requests) and stall_cnt (32b, increments on core_stall), both reset to 0, wrap at 2^32.
REQ-033 Without DMEM_ARB_STATS_EN these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-034 Shared package SHALL hold the state enum (RR, EXT_BURST, YIELD) and port-id constants PORT_CORE=0, PORT_EXT=1.
REQ-035 Single sub-module arb_rr2 (two-input round-robin picker with last_gnt flop); FSM, counter and read routing in top.

Verification
REQ-036 Core-only read addr 0x10, mem_rdata=0xDEADBEEF -> core_gnt same cycle, core_rvalid next cycle with 0xDEADBEEF, ext_rvalid=0.
REQ-037 Both request after reset -> core granted, ext granted next cycle, alternating while both held; core_stall high only on ext cycles.
REQ-038 ext_lock=1, MAX_BURST=4, both requesting continuously -> ext granted 4 cycles, core 1 (YIELD), then round-robin resumes.
REQ-039 ext_lock burst with core_req=0 for 10 cycles -> ext granted all 10, no YIELD, counter holds 4.
REQ-040 Core write 0x55 to 0x20 then ext read 0x20 -> mem_wen one cycle, ext_rvalid with 0x55, core_rvalid never set.
REQ-041 arst_n low in cycle after granted read -> no rvalid; with DMEM_ARB_STATS_EN, conflict_cnt and stall_cnt read 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the arbiter FSM state enum, port identifiers and the burst-counter helper.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      RR        = 2'd0,
      EXT_BURST = 2'd1,
      YIELD     = 2'd2
   } arb_state_e;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_EXT  = 1'b1;

   localparam int CNT_W = 8;

   // Saturating increment: a held burst never wraps past its limit.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                input logic [CNT_W-1:0] lim);
      if (val >= lim) begin
         return lim;
      end
      return val + 1'b1;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core/host requesters, the arbiter and the data SRAM.
// slave: arbiter view; master: environment (core, host, SRAM) view.
interface dmem_arbiter_if
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);

   logic              core_req;
   logic              core_wen;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_gnt;
   logic              core_stall;
   logic [DATA_W-1:0] core_rdata;
   logic              core_rvalid;

   logic              ext_req;
   logic              ext_wen;
   logic              ext_lock;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_gnt;
   logic [DATA_W-1:0] ext_rdata;
   logic              ext_rvalid;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wen;
   logic              mem_ren;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  core_req, core_wen, core_addr, core_wdata,
      input  ext_req, ext_wen, ext_lock, ext_addr, ext_wdata,
      input  mem_rdata,
      output core_gnt, core_stall, core_rdata, core_rvalid,
      output ext_gnt, ext_rdata, ext_rvalid,
      output mem_addr, mem_wdata, mem_wen, mem_ren
   );

   modport master (
      output core_req, core_wen, core_addr, core_wdata,
      output ext_req, ext_wen, ext_lock, ext_addr, ext_wdata,
      output mem_rdata,
      input  core_gnt, core_stall, core_rdata, core_rvalid,
      input  ext_gnt, ext_rdata, ext_rvalid,
      input  mem_addr, mem_wdata, mem_wen, mem_ren
   );

endinterface

// File: rtl/dmem_arbiter_arb_rr2.sv
// Two-input round-robin picker: on a conflict the port not granted most recently wins.
// last_gnt follows the final grant (which the parent may override), not this module's pick.
module arb_rr2
   import dmem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic arst_n,
   input  logic req_core,
   input  logic req_ext,
   input  logic gnt_core,
   input  logic gnt_ext,
   output logic pick_core,
   output logic pick_ext
);

   logic last_gnt;

   // Reset to the host so the core wins the first conflict.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         last_gnt <= PORT_EXT;
      end else if (gnt_core) begin
         last_gnt <= PORT_CORE;
      end else if (gnt_ext) begin
         last_gnt <= PORT_EXT;
      end
   end

   always_comb begin
      pick_core = 1'b0;
      pick_ext  = 1'b0;
      if (req_core && req_ext) begin
         pick_core = (last_gnt == PORT_EXT);
         pick_ext  = (last_gnt == PORT_CORE);
      end else begin
         pick_core = req_core;
         pick_ext  = req_ext;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data SRAM arbiter between the core MEM stage and an external host,
// with locked host bursts bounded by MAX_BURST. Optional statistics: DMEM_ARB_STATS_EN.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MAX_BURST = 8
) (
   input  logic        clk,
   input  logic        arst_n,
   dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0] conflict_cnt,
   output logic [31:0] stall_cnt
`endif
);

   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

   arb_state_e        state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic              pick_core, pick_ext;
   logic              core_gnt, ext_gnt;
   logic              rd_core_p1, rd_ext_p1;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] wdata_sel;

   arb_rr2 u_rr (
      .clk       (clk),
      .arst_n    (arst_n),
      .req_core  (bus.core_req),
      .req_ext   (bus.ext_req),
      .gnt_core  (core_gnt),
      .gnt_ext   (ext_gnt),
      .pick_core (pick_core),
      .pick_ext  (pick_ext)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= RR;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      core_gnt   = 1'b0;
      ext_gnt    = 1'b0;
      case (state)
         RR: begin
            core_gnt = pick_core;
            ext_gnt  = pick_ext;
            cnt_next = '0;
            if (pick_ext && bus.ext_lock) begin
               cnt_next = CNT_W'(1);
               // A one-grant burst is already exhausted on entry.
               if ((BURST_LIM == CNT_W'(1)) && bus.core_req) begin
                  state_next = YIELD;
               end else begin
                  state_next = EXT_BURST;
               end
            end
         end
         EXT_BURST: begin
            ext_gnt  = bus.ext_req;
            core_gnt = bus.core_req && !bus.ext_req;
            if (bus.ext_req) begin
               cnt_next = sat_inc(cnt, BURST_LIM);
            end
            if (!bus.ext_lock || !bus.ext_req) begin
               state_next = RR;
               cnt_next   = '0;
            end else if ((cnt_next == BURST_LIM) && bus.core_req) begin
               state_next = YIELD;
            end
         end
         YIELD: begin
            core_gnt   = bus.core_req;
            state_next = RR;
            cnt_next   = '0;
         end
         default: begin
            state_next = RR;
            cnt_next   = '0;
         end
      endcase
      // Grants are combinational from requests, so they must be blocked while reset is held.
      if (!arst_n) begin
         core_gnt = 1'b0;
         ext_gnt  = 1'b0;
      end
   end

   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      if (core_gnt) begin
         addr_sel  = bus.core_addr;
         wdata_sel = bus.core_wdata;
      end else if (ext_gnt) begin
         addr_sel  = bus.ext_addr;
         wdata_sel = bus.ext_wdata;
      end
   end

   assign bus.core_gnt   = core_gnt;
   assign bus.ext_gnt    = ext_gnt;
   assign bus.core_stall = bus.core_req && !core_gnt;
   assign bus.mem_addr   = addr_sel;
   assign bus.mem_wdata  = wdata_sel;
   assign bus.mem_wen    = (core_gnt && bus.core_wen) || (ext_gnt && bus.ext_wen);
   assign bus.mem_ren    = (core_gnt && !bus.core_wen) || (ext_gnt && !bus.ext_wen);

   // Read-owner stage: SRAM data returns one cycle after mem_ren.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rd_core_p1 <= 1'b0;
         rd_ext_p1  <= 1'b0;
      end else begin
         rd_core_p1 <= core_gnt && !bus.core_wen;
         rd_ext_p1  <= ext_gnt && !bus.ext_wen;
      end
   end

   assign bus.core_rvalid = rd_core_p1;
   assign bus.ext_rvalid  = rd_ext_p1;
   assign bus.core_rdata  = rd_core_p1 ? bus.mem_rdata : '0;
   assign bus.ext_rdata   = rd_ext_p1 ? bus.mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         conflict_cnt <= '0;
         stall_cnt    <= '0;
      end else begin
         if (bus.core_req && bus.ext_req) begin
            conflict_cnt <= conflict_cnt + 32'd1;
         end
         if (bus.core_stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural SRAM.
module tb_dmem_arbiter;

   localparam int MB = 4;

   logic clk;
   logic arst_n;
   int   checks;
   int   errors;

   dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] conflict_cnt;
   logic [31:0] stall_cnt;
`endif

   dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_BURST(MB)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus.slave)
`ifdef DMEM_ARB_STATS_EN
      ,
      .conflict_cnt (conflict_cnt),
      .stall_cnt    (stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural single-port SRAM with registered read data; idle cycles return junk.
   logic [31:0] mem_arr [0:63] = '{default: 32'h0};
   always @(posedge clk) begin
      if (bus.mem_wen) mem_arr[bus.mem_addr[5:0]] <= bus.mem_wdata;
      bus.mem_rdata <= bus.mem_ren ? mem_arr[bus.mem_addr[5:0]] : $urandom;
   end

   // Reference model state, phrased as the arbitration rules rather than RTL registers.
   logic [31:0] shadow [0:63] = '{default: 32'h0};
   bit          m_last_ext;
   bit          m_in_burst;
   bit          m_yield;
   int          m_burst_len;
   int          m_rd_owner;
   int          m_rd_addr;
   int          m_conf;
   int          m_stall;

   task automatic model_reset();
      m_last_ext  = 1'b1;
      m_in_burst  = 1'b0;
      m_yield     = 1'b0;
      m_burst_len = 0;
      m_rd_owner  = 0;
      m_rd_addr   = 0;
      m_conf      = 0;
      m_stall     = 0;
   endtask

   task automatic model_grant(output bit cg, output bit eg);
      cg = 1'b0;
      eg = 1'b0;
      if (!arst_n) begin
         cg = 1'b0;
      end else if (m_yield) begin
         cg = bus.core_req;
      end else if (m_in_burst) begin
         eg = bus.ext_req;
         cg = bus.core_req && !bus.ext_req;
      end else if (bus.core_req && bus.ext_req) begin
         cg = m_last_ext;
         eg = !m_last_ext;
      end else begin
         cg = bus.core_req;
         eg = bus.ext_req;
      end
   endtask

   task automatic model_commit();
      bit cg, eg;
      model_grant(cg, eg);
      if (!arst_n) begin
         model_reset();
         return;
      end
      if (bus.core_req && bus.ext_req) m_conf++;
      if (bus.core_req && !cg) m_stall++;
      if (cg) m_last_ext = 1'b0;
      else if (eg) m_last_ext = 1'b1;
      if (cg && bus.core_wen) shadow[bus.core_addr[5:0]] = bus.core_wdata;
      if (eg && bus.ext_wen) shadow[bus.ext_addr[5:0]] = bus.ext_wdata;
      m_rd_owner = 0;
      if (cg && !bus.core_wen) begin
         m_rd_owner = 1;
         m_rd_addr  = int'(bus.core_addr[5:0]);
      end else if (eg && !bus.ext_wen) begin
         m_rd_owner = 2;
         m_rd_addr  = int'(bus.ext_addr[5:0]);
      end
      if (m_yield) begin
         m_yield = 1'b0;
         m_burst_len = 0;
      end else if (m_in_burst) begin
         if (eg && m_burst_len < MB) m_burst_len++;
         if (!bus.ext_lock || !bus.ext_req) begin
            m_in_burst = 1'b0;
         end else if (m_burst_len == MB && bus.core_req) begin
            m_in_burst = 1'b0;
            m_yield    = 1'b1;
         end
      end else if (eg && bus.ext_lock) begin
         m_burst_len = 1;
         if (MB == 1 && bus.core_req) m_yield = 1'b1;
         else m_in_burst = 1'b1;
      end
   endtask

   task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                        input bit er, input bit ew, input bit el, input logic [31:0] ea, input logic [31:0] ed);
      bus.core_req   = cr;
      bus.core_wen   = cw;
      bus.core_addr  = ca;
      bus.core_wdata = cd;
      bus.ext_req    = er;
      bus.ext_wen    = ew;
      bus.ext_lock   = el;
      bus.ext_addr   = ea;
      bus.ext_wdata  = ed;
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      arst_n = 1'b0;
      model_reset();
      tick();
      tick();
      arst_n = 1'b1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      model_reset();
      drive(1, 1, 32'h24, 32'h1234, 1, 0, 1, 32'h28, 32'h5678);
      #4;
      checks++; if (bus.core_gnt !== 1'b0) begin errors++; $display("FAIL reset_core_gnt got=%b exp=0", bus.core_gnt); end
      checks++; if (bus.ext_gnt !== 1'b0) begin errors++; $display("FAIL reset_ext_gnt got=%b exp=0", bus.ext_gnt); end
      checks++; if (bus.core_stall !== 1'b1) begin errors++; $display("FAIL reset_core_stall got=%b exp=1", bus.core_stall); end
      checks++; if ({bus.mem_wen, bus.mem_ren} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {bus.mem_wen, bus.mem_ren}); end
      checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", bus.mem_addr, bus.mem_wdata); end
      checks++; if ({bus.core_rvalid, bus.ext_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", {bus.core_rvalid, bus.ext_rvalid}); end
      checks++; if (bus.core_rdata !== 32'h0 || bus.ext_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.core_rdata, bus.ext_rdata); end
`ifdef DMEM_ARB_STATS_EN
      checks++; if (conflict_cnt !== 32'h0 || stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", conflict_cnt, stall_cnt); end
`endif
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      arst_n = 1'b1;
   endtask

   task automatic test_core_read();
      do_reset();
      drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      #4;
      checks++; if (bus.mem_wen !== 1'b1) begin errors++; $display("FAIL core_preload_wen got=%b exp=1", bus.mem_wen); end
      tick();
      drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      #4;
      checks++; if (bus.core_gnt !== 1'b1 || bus.core_stall !== 1'b0) begin errors++; $display("FAIL core_read_gnt got=%b/%b exp=1/0", bus.core_gnt, bus.core_stall); end
      checks++; if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 32'h10) begin errors++; $display("FAIL core_read_mem got=%b/%h exp=1/10", bus.mem_ren, bus.mem_addr); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      checks++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL core_read_data got=%b/%h exp=1/deadbeef", bus.core_rvalid, bus.core_rdata); end
      checks++; if (bus.ext_rvalid !== 1'b0 || bus.ext_rdata !== 32'h0) begin errors++; $display("FAIL core_read_ext_quiet got=%b/%h exp=0/0", bus.ext_rvalid, bus.ext_rdata); end
      tick();
   endtask

   task automatic test_alternate();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 32'(i), 0, 1, 0, 0, 32'(i + 8), 0);
         #4;
         checks++; if (bus.core_gnt !== (i % 2 == 0) || bus.ext_gnt !== (i % 2 == 1)) begin errors++; $display("FAIL alternate_gnt cyc=%0d got=%b%b exp=%b%b", i, bus.core_gnt, bus.ext_gnt, i % 2 == 0, i % 2 == 1); end
         checks++; if (bus.core_stall !== (i % 2 == 1)) begin errors++; $display("FAIL alternate_stall cyc=%0d got=%b exp=%b", i, bus.core_stall, i % 2 == 1); end
         tick();
      end
   endtask

   task automatic test_burst_yield();
      logic [10:0] ext_pat;
      ext_pat = 11'b01111011110;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(1, 0, 32'h1, 0, 1, 0, 1, 32'h2, 0);
         #4;
         checks++; if (bus.ext_gnt !== ext_pat[i] || bus.core_gnt !== !ext_pat[i]) begin errors++; $display("FAIL burst_yield cyc=%0d got=%b%b exp=%b%b", i, bus.core_gnt, bus.ext_gnt, !ext_pat[i], ext_pat[i]); end
         tick();
      end
   endtask

   task automatic test_burst_no_core();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 0, 1, 0, 1, 32'(i), 0);
         #4;
         checks++; if (bus.ext_gnt !== 1'b1 || bus.core_gnt !== 1'b0) begin errors++; $display("FAIL burst_solo cyc=%0d got=%b%b exp=01", i, bus.core_gnt, bus.ext_gnt); end
         tick();
      end
      // Saturated burst: one more host grant, then the core gets its yield slot.
      drive(1, 0, 0, 0, 1, 0, 1, 0, 0);
      #4;
      checks++; if (bus.ext_gnt !== 1'b1 || bus.core_gnt !== 1'b0) begin errors++; $display("FAIL burst_sat_last got=%b%b exp=01", bus.core_gnt, bus.ext_gnt); end
      tick();
      #4;
      checks++; if (bus.core_gnt !== 1'b1 || bus.ext_gnt !== 1'b0) begin errors++; $display("FAIL burst_sat_yield got=%b%b exp=10", bus.core_gnt, bus.ext_gnt); end
      tick();
      #4;
      checks++; if (bus.ext_gnt !== 1'b1 || bus.core_gnt !== 1'b0) begin errors++; $display("FAIL burst_sat_resume got=%b%b exp=01", bus.core_gnt, bus.ext_gnt); end
      tick();
   endtask

   task automatic test_write_then_read();
      do_reset();
      drive(1, 1, 32'h20, 32'h55, 0, 0, 0, 0, 0);
      #4;
      checks++; if (bus.mem_wen !== 1'b1 || bus.mem_ren !== 1'b0 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h55) begin errors++; $display("FAIL wr_strobe got=%b%b/%h/%h exp=10/20/55", bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_wdata); end
      tick();
      drive(0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
      #4;
      checks++; if (bus.ext_gnt !== 1'b1 || bus.mem_wen !== 1'b0 || bus.mem_ren !== 1'b1) begin errors++; $display("FAIL rd_strobe got=%b/%b%b exp=1/01", bus.ext_gnt, bus.mem_wen, bus.mem_ren); end
      checks++; if (bus.core_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got=%b exp=0", bus.core_rvalid); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      checks++; if (bus.ext_rvalid !== 1'b1 || bus.ext_rdata !== 32'h55) begin errors++; $display("FAIL ext_rd_data got=%b/%h exp=1/55", bus.ext_rvalid, bus.ext_rdata); end
      checks++; if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== 32'h0) begin errors++; $display("FAIL ext_rd_core_quiet got=%b/%h exp=0/0", bus.core_rvalid, bus.core_rdata); end
      tick();
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h11, 0);
      #4;
      checks++; if (bus.core_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt got=%b exp=1", bus.core_gnt); end
      tick();
      arst_n = 1'b0;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      checks++; if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== 32'h0 || bus.ext_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got=%b/%h/%b exp=0/0/0", bus.core_rvalid, bus.core_rdata, bus.ext_rvalid); end
`ifdef DMEM_ARB_STATS_EN
      checks++; if (conflict_cnt !== 32'h0 || stall_cnt !== 32'h0) begin errors++; $display("FAIL midrst_stats got=%0d/%0d exp=0/0", conflict_cnt, stall_cnt); end
`endif
      tick();
      arst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      bit          cg, eg;
      logic [31:0] e_addr, e_wdata, e_crd, e_erd;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 32'($urandom_range(0, 63)), $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
               32'($urandom_range(0, 63)), $urandom);
         #4;
         model_grant(cg, eg);
         e_addr  = cg ? bus.core_addr : (eg ? bus.ext_addr : 32'h0);
         e_wdata = cg ? bus.core_wdata : (eg ? bus.ext_wdata : 32'h0);
         e_crd   = (m_rd_owner == 1) ? shadow[m_rd_addr] : 32'h0;
         e_erd   = (m_rd_owner == 2) ? shadow[m_rd_addr] : 32'h0;
         checks++; if (bus.core_gnt !== cg || bus.ext_gnt !== eg) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b%b exp=%b%b", i, bus.core_gnt, bus.ext_gnt, cg, eg); end
         checks++; if (bus.core_stall !== (bus.core_req && !cg)) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, bus.core_stall, bus.core_req && !cg); end
         checks++; if (bus.mem_wen !== ((cg && bus.core_wen) || (eg && bus.ext_wen)) || bus.mem_ren !== ((cg && !bus.core_wen) || (eg && !bus.ext_wen))) begin errors++; $display("FAIL rnd_strobe cyc=%0d got=%b%b", i, bus.mem_wen, bus.mem_ren); end
         checks++; if (bus.mem_addr !== e_addr || bus.mem_wdata !== e_wdata) begin errors++; $display("FAIL rnd_bus cyc=%0d got=%h/%h exp=%h/%h", i, bus.mem_addr, bus.mem_wdata, e_addr, e_wdata); end
         checks++; if (bus.core_rvalid !== (m_rd_owner == 1) || bus.core_rdata !== e_crd) begin errors++; $display("FAIL rnd_core_rd cyc=%0d got=%b/%h exp=%b/%h", i, bus.core_rvalid, bus.core_rdata, m_rd_owner == 1, e_crd); end
         checks++; if (bus.ext_rvalid !== (m_rd_owner == 2) || bus.ext_rdata !== e_erd) begin errors++; $display("FAIL rnd_ext_rd cyc=%0d got=%b/%h exp=%b/%h", i, bus.ext_rvalid, bus.ext_rdata, m_rd_owner == 2, e_erd); end
         tick();
      end
`ifdef DMEM_ARB_STATS_EN
      checks++; if (conflict_cnt !== 32'(m_conf) || stall_cnt !== 32'(m_stall)) begin errors++; $display("FAIL rnd_stats got=%0d/%0d exp=%0d/%0d", conflict_cnt, stall_cnt, m_conf, m_stall); end
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      arst_n = 1'b0;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      test_reset();
      test_core_read();
      test_alternate();
      test_burst_yield();
      test_burst_no_core();
      test_write_then_read();
      test_reset_mid_read();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
